// File: rtl/pine16_bus_pkg.sv
// Shared definitions for the pine16 chip-select sequencer: FSM state encoding
// and the chip-select count helper.
package pine16_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_TURN   = 2'd3
  } seqState_t;

  localparam int DEFAULT_SEL_W = 3;
  localparam int NUM_CS        = 1 << DEFAULT_SEL_W;

  function automatic int numCs(input int selW);
    return 1 << selW;
  endfunction

endpackage

// File: rtl/bus_cs_sequencer_if.sv
// Bus-side signal bundle between the pine16 master and the chip-select sequencer.
interface bus_cs_sequencer_if
  import pine16_bus_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int WS_W  = 3
);
  localparam int NCS = numCs(SEL_W);

  logic [SEL_W-1:0]    addr_sel;
  logic                g1;
  logic                g2a_n;
  logic                g2b_n;
  logic                req;
  logic [NCS*WS_W-1:0] ws_cfg;
  logic [NCS-1:0]      cs_n;
  logic                ready;
  logic                abort;
  logic                busy;

  modport master (
    output addr_sel, g1, g2a_n, g2b_n, req, ws_cfg,
    input  cs_n, ready, abort, busy
  );

  modport slave (
    input  addr_sel, g1, g2a_n, g2b_n, req, ws_cfg,
    output cs_n, ready, abort, busy
  );

endinterface

// File: rtl/onehot_decoder_n.sv
// Combinational select-to-active-low one-hot decoder; generalised 3-to-8 part.
module onehot_decoder_n #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_en,
  output logic [(1<<SEL_W)-1:0] o_cs_n
);

  always_comb begin
    o_cs_n = '1;
    if (i_en) o_cs_n[i_sel] = 1'b0;
  end

endmodule

// File: rtl/bus_cs_sequencer.sv
// Region chip-select sequencer: decodes the select, holds the chip select for a
// programmable number of wait states, pulses ready, then enforces a turnaround.
module bus_cs_sequencer
  import pine16_bus_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int WS_W       = 3,
  parameter int TURNAROUND = 1
) (
  input  logic               clk,
  input  logic               rst,
  bus_cs_sequencer_if.slave  bus
);

  localparam int NCS  = numCs(SEL_W);
  localparam int TC_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [TC_W-1:0] TC_LOAD = TC_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  seqState_t        r_state, w_nextState;
  logic [SEL_W-1:0] r_sel, w_nextSel;
  logic [WS_W-1:0]  r_wcnt, w_nextWcnt;
  logic [TC_W-1:0]  r_tcnt, w_nextTcnt;
  logic [NCS-1:0]   r_cs_n, w_nextCsN;
  logic             r_ready, r_abort, r_busy;
  logic             w_nextReady, w_nextAbort, w_csEn, w_en;
  logic [WS_W-1:0]  w_wsArr [NCS];

  for (genvar k = 0; k < NCS; k++) begin : g_wsSlice
    assign w_wsArr[k] = bus.ws_cfg[k*WS_W +: WS_W];
  end

  assign w_en = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;

  always_comb begin
    w_nextState = r_state;
    w_nextSel   = r_sel;
    w_nextWcnt  = r_wcnt;
    w_nextTcnt  = r_tcnt;
    w_nextReady = 1'b0;
    w_nextAbort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req && w_en) begin
          w_nextState = ST_ACCESS;
          w_nextSel   = bus.addr_sel;
          w_nextWcnt  = w_wsArr[bus.addr_sel];
        end
      end
      ST_ACCESS: begin
        // Losing the enable cancels the access even on its final wait cycle.
        if (!w_en) begin
          w_nextAbort = 1'b1;
          w_nextState = (TURNAROUND > 0) ? ST_TURN : ST_IDLE;
          w_nextTcnt  = TC_LOAD;
        end else if (r_wcnt == '0) begin
          w_nextState = ST_DONE;
          w_nextReady = 1'b1;
        end else begin
          w_nextWcnt = r_wcnt - WS_W'(1);
        end
      end
      ST_DONE: begin
        w_nextAbort = ~w_en;
        w_nextState = (TURNAROUND > 0) ? ST_TURN : ST_IDLE;
        w_nextTcnt  = TC_LOAD;
      end
      ST_TURN: begin
        if (r_tcnt == '0) w_nextState = ST_IDLE;
        else              w_nextTcnt  = r_tcnt - TC_W'(1);
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The decoder sees next-state values so cs_n can be taken straight from a flop.
  assign w_csEn = (w_nextState == ST_ACCESS) || (w_nextState == ST_DONE);

  onehot_decoder_n #(.SEL_W(SEL_W)) u_decoder (
    .i_sel  (w_nextSel),
    .i_en   (w_csEn),
    .o_cs_n (w_nextCsN)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_wcnt  <= '0;
      r_tcnt  <= '0;
      r_cs_n  <= '1;
      r_ready <= 1'b0;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_sel   <= w_nextSel;
      r_wcnt  <= w_nextWcnt;
      r_tcnt  <= w_nextTcnt;
      r_cs_n  <= w_nextCsN;
      r_ready <= w_nextReady;
      r_abort <= w_nextAbort;
      r_busy  <= (w_nextState != ST_IDLE);
    end
  end

  assign bus.cs_n  = r_cs_n;
  assign bus.ready = r_ready;
  assign bus.abort = r_abort;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_bus_cs_sequencer.sv
// Scoreboard bench: two sequencer configurations driven by directed and random
// stimulus, compared every cycle against a cycle-countdown reference model.
module tb_bus_cs_sequencer;

  typedef struct {
    int csLeft;
    int turnLeft;
    int sel;
  } mState_t;

  typedef struct packed {
    logic [15:0] csN;
    logic        ready;
    logic        abort;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  mState_t stA = '{0, 0, 0};
  mState_t stB = '{0, 0, 0};
  exp_t    qA[$];
  exp_t    qB[$];

  bus_cs_sequencer_if #(.SEL_W(3), .WS_W(3)) busA ();
  bus_cs_sequencer_if #(.SEL_W(4), .WS_W(2)) busB ();

  bus_cs_sequencer #(.SEL_W(3), .WS_W(3), .TURNAROUND(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  bus_cs_sequencer #(.SEL_W(4), .WS_W(2), .TURNAROUND(0)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  always #5 clk = ~clk;

  // An access holds its chip select for W+2 cycles, ready in the last one,
  // followed by t idle-high cycles; losing enable mid-access cancels it.
  function automatic mState_t modelStep(input mState_t s, input bit req, input bit en,
                                        input int sel, input int w, input int t,
                                        output exp_t e);
    mState_t n = s;
    bit rdy = 1'b0;
    bit ab  = 1'b0;
    if (n.csLeft > 0) begin
      if (!en) begin
        ab = 1'b1;
        n.csLeft = 0;
        n.turnLeft = t;
      end else begin
        n.csLeft = n.csLeft - 1;
        if (n.csLeft == 1) rdy = 1'b1;
        else if (n.csLeft == 0) n.turnLeft = t;
      end
    end else if (n.turnLeft > 0) begin
      n.turnLeft = n.turnLeft - 1;
    end else if (req && en) begin
      n.csLeft = w + 2;
      n.sel = sel;
    end
    e.csN = '1;
    if (n.csLeft > 0) e.csN[n.sel] = 1'b0;
    e.ready = rdy;
    e.abort = ab;
    e.busy  = (n.csLeft > 0) || (n.turnLeft > 0);
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   s;
    if (rst) begin
      stA = '{0, 0, 0};
      stB = '{0, 0, 0};
      qA.delete();
      qB.delete();
    end else begin
      s = int'(busA.addr_sel);
      stA = modelStep(stA, busA.req, busA.g1 & ~busA.g2a_n & ~busA.g2b_n, s,
                      int'((busA.ws_cfg >> (s * 3)) & 24'h7), 1, e);
      qA.push_back(e);
      s = int'(busB.addr_sel);
      stB = modelStep(stB, busB.req, busB.g1 & ~busB.g2a_n & ~busB.g2b_n, s,
                      int'((busB.ws_cfg >> (s * 2)) & 32'h3), 0, e);
      qB.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (qA.size() > 0) begin
        e = qA.pop_front();
        checkOutput("A.cs_n",  {16'h0, 8'hFF, busA.cs_n}, {16'h0, e.csN});
        checkOutput("A.ready", {31'h0, busA.ready}, {31'h0, e.ready});
        checkOutput("A.abort", {31'h0, busA.abort}, {31'h0, e.abort});
        checkOutput("A.busy",  {31'h0, busA.busy},  {31'h0, e.busy});
      end
      if (qB.size() > 0) begin
        e = qB.pop_front();
        checkOutput("B.cs_n",  {16'h0, busB.cs_n}, {16'h0, e.csN});
        checkOutput("B.ready", {31'h0, busB.ready}, {31'h0, e.ready});
        checkOutput("B.abort", {31'h0, busB.abort}, {31'h0, e.abort});
        checkOutput("B.busy",  {31'h0, busB.busy},  {31'h0, e.busy});
      end
      checkOutput("A.onehot", {31'h0, ($countones(~busA.cs_n) <= 1)}, 32'h1);
      checkOutput("B.onehot", {31'h0, ($countones(~busB.cs_n) <= 1)}, 32'h1);
    end
  end

  task automatic applyStimulus(input bit r, input bit g1v, input bit g2a, input bit g2b,
                               input int sel, input int cycles);
    busA.req      = r;
    busA.g1       = g1v;
    busA.g2a_n    = g2a;
    busA.g2b_n    = g2b;
    busA.addr_sel = 3'(sel);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkIdleNow(input string tag);
    checkOutput({tag, ".A.cs_n"}, {24'h0, busA.cs_n}, 32'hFF);
    checkOutput({tag, ".A.ready"}, {31'h0, busA.ready}, 32'h0);
    checkOutput({tag, ".A.abort"}, {31'h0, busA.abort}, 32'h0);
    checkOutput({tag, ".A.busy"}, {31'h0, busA.busy}, 32'h0);
    checkOutput({tag, ".B.cs_n"}, {16'h0, busB.cs_n}, 32'hFFFF);
    checkOutput({tag, ".B.busy"}, {31'h0, busB.busy}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busA.ws_cfg = 24'($urandom);
    busA.ws_cfg[0*3 +: 3] = 3'd0;
    busA.ws_cfg[5*3 +: 3] = 3'd3;
    busA.ws_cfg[7*3 +: 3] = 3'd7;
    busB.ws_cfg = 32'hFFFF_FFFF;
    busB.req = 1'b0; busB.g1 = 1'b1; busB.g2a_n = 1'b0; busB.g2b_n = 1'b0;
    busB.addr_sel = 4'd0;
    busA.req = 1'b0; busA.g1 = 1'b1; busA.g2a_n = 1'b0; busA.g2b_n = 1'b0;
    busA.addr_sel = 3'd0;

    #1 rst = 1'b1;
    #1 checkIdleNow("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    applyStimulus(1, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 5);

    $display("[TB] back-to-back accesses on region 5");
    applyStimulus(1, 1, 0, 0, 5, 21);
    applyStimulus(0, 1, 0, 0, 5, 6);

    $display("[TB] disabled request on region 3");
    applyStimulus(1, 1, 0, 1, 3, 10);
    applyStimulus(0, 1, 0, 0, 3, 2);

    $display("[TB] abort on region 7");
    applyStimulus(1, 1, 0, 0, 7, 1);
    applyStimulus(0, 1, 0, 0, 7, 1);
    applyStimulus(0, 0, 0, 0, 7, 3);
    applyStimulus(0, 1, 0, 0, 7, 3);

    $display("[TB] reset during access on region 5");
    applyStimulus(1, 1, 0, 0, 5, 1);
    applyStimulus(0, 1, 0, 0, 5, 1);
    #2 rst = 1'b1;
    #1 checkIdleNow("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1, 0, 0, 0, 2);

    $display("[TB] sixteen-region sweep with no turnaround");
    busB.req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      busB.addr_sel = 4'(k);
      repeat (6) @(negedge clk);
    end
    busB.req = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      busA.req   = ($urandom_range(0, 3) != 0);
      busA.g1    = ($urandom_range(0, 15) != 0);
      busA.g2a_n = ($urandom_range(0, 15) == 0);
      busA.g2b_n = ($urandom_range(0, 15) == 0);
      busA.addr_sel = 3'($urandom);
      if ($urandom_range(0, 19) == 0) busA.ws_cfg = 24'($urandom);
      busB.req   = ($urandom_range(0, 3) != 0);
      busB.g1    = ($urandom_range(0, 15) != 0);
      busB.g2a_n = ($urandom_range(0, 15) == 0);
      busB.g2b_n = ($urandom_range(0, 15) == 0);
      busB.addr_sel = 4'($urandom);
      if ($urandom_range(0, 19) == 0) busB.ws_cfg = $urandom;
      @(negedge clk);
    end
    busA.req = 1'b0;
    busB.req = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
